// File: rtl/bit_pattern_detector.sv
// Serial bit-pattern detector: matches a runtime-loadable PAT_W-bit pattern on a
// qualified bit stream, with optional overlap and a saturating match counter.
module bit_pattern_detector #(
  parameter int unsigned      PAT_W    = 4,
  parameter int unsigned      CNT_W    = 16,
  parameter int unsigned      OVERLAP  = 1,
  parameter logic [PAT_W-1:0] PAT_INIT = {PAT_W{1'b1}}
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_load,
  input  logic [PAT_W-1:0]                 cfg_pattern,
  input  logic                             in_valid,
  input  logic                             in_bit,
  input  logic                             clear,
  output logic                             match,
  output logic [CNT_W-1:0]                 match_count,
  output logic                             count_sat,
  output logic [$clog2(PAT_W+1)-1:0]       fill,
  output logic                             armed
);

  localparam int unsigned         FILL_W  = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]   FULL    = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pattern, pat_nxt;
  logic [PAT_W-1:0]   history, hist_nxt, shifted;
  logic [FILL_W-1:0]  fill_nxt, fill_inc;
  logic               hit, hit_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat_nxt;

  // State, history and pattern registers; the hit is staged once so that the
  // match pulse and counter land one edge after the history shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      pattern     <= PAT_INIT;
      history     <= '0;
      fill        <= '0;
      armed       <= 1'b0;
      hit_q       <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pattern     <= pat_nxt;
      history     <= hist_nxt;
      fill        <= fill_nxt;
      armed       <= (state_nxt == ARMED);
      hit_q       <= hit;
      match       <= hit_q;
      match_count <= cnt_nxt;
      count_sat   <= sat_nxt;
    end
  end

  // Next-state: cfg_load outranks in_valid and discards the incoming bit.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pattern;
    hist_nxt  = history;
    fill_nxt  = fill;
    hit       = 1'b0;
    shifted   = {history[PAT_W-2:0], in_bit};
    fill_inc  = (fill == FULL) ? fill : fill + FILL_W'(1);

    if (cfg_load) begin
      pat_nxt   = cfg_pattern;
      hist_nxt  = '0;
      fill_nxt  = '0;
      state_nxt = FILL;
    end else if (in_valid) begin
      hist_nxt = shifted;
      fill_nxt = fill_inc;
      hit      = (fill_inc == FULL) && (shifted == pattern);
      if (hit && (OVERLAP == 0)) begin
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        state_nxt = (fill_inc == FULL) ? ARMED : FILL;
      end
    end
  end

  // Saturating counter; clear wins over a coincident hit.
  always_comb begin
    cnt_nxt = match_count;
    sat_nxt = count_sat;
    if (clear) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (hit_q && (match_count != CNT_MAX)) begin
      cnt_nxt = match_count + CNT_W'(1);
      if (cnt_nxt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_pattern_detector.sv
// Directed bench for bit_pattern_detector: a vector table for the basic and
// overlap/non-overlap streams, then hand sequences for gaps, priority, saturation, reset.
module tb_bit_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       in_valid;
  logic       in_bit;
  logic       clear;

  logic        a_match, b_match, c_match;
  logic [15:0] a_count, b_count;
  logic [1:0]  c_count;
  logic        a_sat, b_sat, c_sat;
  logic [2:0]  a_fill, b_fill, c_fill;
  logic        a_armed, b_armed, c_armed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_pattern_detector #(.PAT_W(4), .CNT_W(16), .OVERLAP(1)) u_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(a_match), .match_count(a_count), .count_sat(a_sat),
    .fill(a_fill), .armed(a_armed));

  bit_pattern_detector #(.PAT_W(4), .CNT_W(16), .OVERLAP(0)) u_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(b_match), .match_count(b_count), .count_sat(b_sat),
    .fill(b_fill), .armed(b_armed));

  bit_pattern_detector #(.PAT_W(4), .CNT_W(2), .OVERLAP(1)) u_c (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(c_match), .match_count(c_count), .count_sat(c_sat),
    .fill(c_fill), .armed(c_armed));

  typedef struct {
    logic        cl;
    logic [3:0]  pat;
    logic        v;
    logic        b;
    logic        clr;
    logic        am;
    logic [15:0] ac;
    logic [2:0]  af;
    logic        aa;
    logic        chk_b;
    logic        bm;
    logic [15:0] bc;
    logic [2:0]  bf;
    logic        ba;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cl, input logic [3:0] pat, input logic v,
                              input logic b, input logic clr, input logic am,
                              input logic [15:0] ac, input logic [2:0] af, input logic aa,
                              input logic chk_b, input logic bm, input logic [15:0] bc,
                              input logic [2:0] bf, input logic ba);
    vec_t r;
    r.cl = cl; r.pat = pat; r.v = v; r.b = b; r.clr = clr;
    r.am = am; r.ac = ac; r.af = af; r.aa = aa;
    r.chk_b = chk_b; r.bm = bm; r.bc = bc; r.bf = bf; r.ba = ba;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and return just after the sampling edge.
  task automatic step(input logic cl, input logic [3:0] pat, input logic v,
                      input logic b, input logic clr);
    cfg_load    = cl;
    cfg_pattern = pat;
    in_valid    = v;
    in_bit      = b;
    clear       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 4'h0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0] seq;
  logic [1:0] exp_c [8];
  logic       exp_s [8];
  logic       exp_m [8];

  initial begin
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_match", 32'(a_match), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_sat",   32'(a_sat),   32'd0);
    chk("rst_fill",  32'(a_fill),  32'd0);
    chk("rst_armed", 32'(a_armed), 32'd0);
    reset = 1'b0;

    //             cl pat    v  b  clr  am ac  af aa  chkb bm bc bf ba
    tbl.push_back(mk(1, 4'hB, 0, 0, 0,  0, 0,  0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  0, 0,  1, 0,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0,  0, 0,  2, 0,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  0, 0,  3, 0,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  0, 0,  4, 1,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0,  1, 1,  4, 1,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0,  0, 1,  4, 1,  0,   0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 0, 0, 0,  0, 1,  0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 1,  0, 0,  0, 0,  1,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  0, 0,  1, 0,  1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0,  0, 0,  2, 0,  1,   0, 0, 2, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  0, 0,  3, 0,  1,   0, 0, 3, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0,  0, 0,  4, 1,  1,   0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  1, 1,  4, 1,  1,   1, 1, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0,  0, 1,  4, 1,  1,   0, 1, 2, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0,  1, 2,  4, 1,  1,   0, 1, 3, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0,  0, 2,  4, 1,  1,   0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0,  1, 3,  4, 1,  1,   1, 2, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0,  0, 3,  4, 1,  1,   0, 2, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].cl, tbl[i].pat, tbl[i].v, tbl[i].b, tbl[i].clr);
      chk($sformatf("tbl%0d_a_match", i), 32'(a_match), 32'(tbl[i].am));
      chk($sformatf("tbl%0d_a_count", i), 32'(a_count), 32'(tbl[i].ac));
      chk($sformatf("tbl%0d_a_fill",  i), 32'(a_fill),  32'(tbl[i].af));
      chk($sformatf("tbl%0d_a_armed", i), 32'(a_armed), 32'(tbl[i].aa));
      if (tbl[i].chk_b) begin
        chk($sformatf("tbl%0d_b_match", i), 32'(b_match), 32'(tbl[i].bm));
        chk($sformatf("tbl%0d_b_count", i), 32'(b_count), 32'(tbl[i].bc));
        chk($sformatf("tbl%0d_b_fill",  i), 32'(b_fill),  32'(tbl[i].bf));
        chk($sformatf("tbl%0d_b_armed", i), 32'(b_armed), 32'(tbl[i].ba));
      end
    end

    // Pattern 1011 with three idle cycles after each bit: fill holds in gaps.
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    seq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      bit_in(seq[3-i]);
      chk($sformatf("gap_fill_bit%0d", i), 32'(a_fill), 32'(i + 1));
      for (int g = 0; g < 3; g++) begin
        idle();
        chk($sformatf("gap_match_%0d_%0d", i, g), 32'(a_match),
            32'((i == 3) && (g == 0)));
        chk($sformatf("gap_fill_%0d_%0d", i, g), 32'(a_fill), 32'(i + 1));
      end
    end
    chk("gap_count", 32'(a_count), 32'd4);

    // cfg_load with a valid bit in the same cycle discards that bit.
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("pri_fill_pre", 32'(a_fill), 32'd3);
    step(1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("pri_fill",  32'(a_fill),  32'd0);
    chk("pri_armed", 32'(a_armed), 32'd0);
    chk("pri_count", 32'(a_count), 32'd4);
    for (int i = 0; i < 4; i++) bit_in(1'b0);
    chk("pri_fill4", 32'(a_fill), 32'd4);
    chk("pri_nomatch_yet", 32'(a_match), 32'd0);
    idle();
    chk("pri_match", 32'(a_match), 32'd1);
    chk("pri_count_after", 32'(a_count), 32'd5);

    // clear coincident with the counter update: pulse survives, count zeroed.
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_hit_match", 32'(a_match), 32'd1);
    chk("clr_hit_count", 32'(a_count), 32'd0);
    chk("clr_hit_sat",   32'(a_sat),   32'd0);

    // Saturation on a 2-bit counter with an all-ones self-overlapping pattern.
    step(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
    chk("sat_pre_count", 32'(c_count), 32'd0);
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      if (i < 7) bit_in(1'b1);
      else       idle();
      chk($sformatf("sat_count_%0d", i), 32'(c_count), 32'(exp_c[i]));
      chk($sformatf("sat_flag_%0d",  i), 32'(c_sat),   32'(exp_s[i]));
      chk($sformatf("sat_match_%0d", i), 32'(c_match), 32'(exp_m[i]));
    end
    idle();
    chk("sat_hold_count", 32'(c_count), 32'd3);
    chk("sat_hold_flag",  32'(c_sat),   32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("sat_clr_count", 32'(c_count), 32'd0);
    chk("sat_clr_flag",  32'(c_sat),   32'd0);

    // Reset mid-stream restores PAT_INIT and drops partial history.
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("mrst_match", 32'(a_match), 32'd0);
    chk("mrst_count", 32'(a_count), 32'd0);
    chk("mrst_sat",   32'(a_sat),   32'd0);
    chk("mrst_fill",  32'(a_fill),  32'd0);
    chk("mrst_armed", 32'(a_armed), 32'd0);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    chk("mrst_fill3", 32'(a_fill), 32'd3);
    bit_in(1'b1);
    chk("mrst_armed4", 32'(a_armed), 32'd1);
    idle();
    chk("mrst_init_match", 32'(a_match), 32'd1);
    chk("mrst_init_count", 32'(a_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
